// File: rtl/simple_phase_sequencer.sv
// simple_phase_sequencer: multi-cycle P1..P5 phase controller for the SIMPLE core.
module simple_phase_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [15:0]      ir,
    input  logic [3:0]       alu_flags,
    input  logic             mem_ready,
    output logic [4:0]       phase,
    output logic             mem_rd,
    output logic             mem_wren,
    output logic             mem_addr_sel,
    output logic             ir_load,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             ab_load,
    output logic             dr_load,
    output logic             flag_load,
    output logic             rf_wren,
    output logic             rf_wsel,
    output logic             out_load,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);
    typedef enum logic [2:0] {S_IDLE, S_P1, S_P2, S_P3, S_P4, S_P5, S_HALTED} state_t;
    state_t state, nxt;
    logic [3:0] flags;
    logic retire;
    logic is_arith, is_cmp, is_out, is_halt, is_ld, is_st, is_li, is_b, is_bc, is_mem, is_br;
    logic cond, taken;
    logic unused_ir;
    assign unused_ir = ^ir[3:0];
    assign is_arith = ir[15:14] == 2'b11;
    assign is_cmp   = is_arith && ir[7:4] == 4'b0101;
    assign is_out   = is_arith && ir[7:4] == 4'b1101;
    assign is_halt  = is_arith && ir[7:4] == 4'b1111;
    assign is_ld    = ir[15:14] == 2'b00;
    assign is_st    = ir[15:14] == 2'b01;
    assign is_li    = ir[15:14] == 2'b10 && ir[13:11] == 3'b000;
    assign is_b     = ir[15:14] == 2'b10 && ir[13:11] == 3'b100;
    assign is_bc    = ir[15:14] == 2'b10 && ir[13:11] == 3'b111;
    assign is_mem   = is_ld | is_st;
    assign is_br    = is_b | is_bc;
    // flags are {V,C,Z,S}; branches test the latched copy, never live alu_flags
    assign cond  = ir[10:8] == 3'd0 ? flags[1] :
                   ir[10:8] == 3'd1 ? flags[0] ^ flags[3] :
                   ir[10:8] == 3'd2 ? flags[1] | (flags[0] ^ flags[3]) :
                   ir[10:8] == 3'd3 ? !flags[1] : 1'b0;
    assign taken = is_b | (is_bc & cond);
    always_comb begin
        nxt    = state;
        retire = 1'b0;
        case (state)
            S_IDLE: nxt = S_P1;
            S_P1:   nxt = mem_ready ? S_P2 : S_P1;
            S_P2: begin
                nxt    = is_halt ? S_HALTED : S_P3;
                retire = is_halt;
            end
            S_P3: begin
                nxt    = (is_mem | is_br) ? S_P4 : (is_cmp | !(is_arith | is_li)) ? S_P1 : S_P5;
                retire = !(is_mem | is_br) && (is_cmp | !(is_arith | is_li));
            end
            S_P4: begin
                nxt    = is_br ? S_P1 : !mem_ready ? S_P4 : is_ld ? S_P5 : S_P1;
                retire = is_br | (is_st & mem_ready);
            end
            S_P5: begin
                nxt    = S_P1;
                retire = 1'b1;
            end
            S_HALTED: nxt = S_HALTED;
            default:  nxt = S_IDLE;
        endcase
    end
    assign phase        = {state == S_P5, state == S_P4, state == S_P3, state == S_P2, state == S_P1};
    assign mem_rd       = phase[0] | (phase[3] & is_ld);
    assign mem_wren     = phase[3] & is_st;
    assign mem_addr_sel = phase[3] & is_mem;
    assign ir_load      = phase[0] & mem_ready;
    assign pc_inc       = phase[0] & mem_ready;
    assign pc_load      = phase[3] & is_br & taken;
    assign ab_load      = phase[1];
    assign dr_load      = phase[2];
    assign flag_load    = phase[2] & is_arith & !is_out & !is_halt;
    assign rf_wren      = phase[4] & !is_out;
    assign rf_wsel      = phase[4] & is_ld;
    assign out_load     = phase[4] & is_out;
    assign halted       = state == S_HALTED;
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            flags       <= 4'd0;
            instr_count <= '0;
        end else begin
            state <= nxt;
            if (flag_load) flags <= alu_flags;
            if (retire) instr_count <= instr_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_simple_phase_sequencer.sv
// tb_simple_phase_sequencer: per-cycle scoreboard of expected phase/strobe vectors.
module tb_simple_phase_sequencer;
    logic clock = 0, reset_n, mem_ready;
    logic [15:0] ir;
    logic [3:0] alu_flags;
    logic [4:0] phase;
    logic mem_rd, mem_wren, mem_addr_sel, ir_load, pc_inc, pc_load, ab_load, dr_load;
    logic flag_load, rf_wren, rf_wsel, out_load, halted;
    logic [15:0] instr_count;
    logic [17:0] obs;
    logic [17:0] exp_q[$];
    int n_checks = 0, n_fail = 0;
    logic [15:0] exp_cnt = 0;
    string cur = "reset";

    localparam logic [17:0] PH1 = 18'd1 << 13, PH2 = 18'd1 << 14, PH3 = 18'd1 << 15;
    localparam logic [17:0] PH4 = 18'd1 << 16, PH5 = 18'd1 << 17, RD = 18'd1 << 12;
    localparam logic [17:0] WRN = 18'd1 << 11, SEL = 18'd1 << 10, IRL = 18'd1 << 9;
    localparam logic [17:0] PCI = 18'd1 << 8, PCL = 18'd1 << 7, AB = 18'd1 << 6;
    localparam logic [17:0] DRL = 18'd1 << 5, FL = 18'd1 << 4, RFW = 18'd1 << 3;
    localparam logic [17:0] WS = 18'd1 << 2, OL = 18'd1 << 1, HLT = 18'd1;
    localparam logic [17:0] F = PH1 | RD | IRL | PCI;

    always #5 clock = ~clock;

    simple_phase_sequencer #(.CNT_W(16)) dut (
        .clock(clock), .reset_n(reset_n), .ir(ir), .alu_flags(alu_flags), .mem_ready(mem_ready),
        .phase(phase), .mem_rd(mem_rd), .mem_wren(mem_wren), .mem_addr_sel(mem_addr_sel),
        .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load), .ab_load(ab_load),
        .dr_load(dr_load), .flag_load(flag_load), .rf_wren(rf_wren), .rf_wsel(rf_wsel),
        .out_load(out_load), .halted(halted), .instr_count(instr_count)
    );

    assign obs = {phase, mem_rd, mem_wren, mem_addr_sel, ir_load, pc_inc, pc_load, ab_load,
                  dr_load, flag_load, rf_wren, rf_wsel, out_load, halted};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // one clock cycle: drive inputs, queue expectation, compare mid-cycle
    task automatic step(input logic rn, input logic mr, input logic [3:0] af,
                        input logic [17:0] e, input bit ret);
        reset_n = rn;
        mem_ready = mr;
        alu_flags = af;
        exp_q.push_back(e);
        @(negedge clock);
        check({cur, " strobes"}, 32'(obs), 32'(exp_q.pop_front()));
        check({cur, " count"}, 32'(instr_count), 32'(exp_cnt));
        @(posedge clock);
        #1;
        if (!rn) exp_cnt = 0;
        else if (ret) exp_cnt++;
    endtask

    task automatic front(input string name, input logic [15:0] i);
        cur = name;
        ir = i;
        step(1, 1, 4'h0, F, 0);
        step(1, 0, 4'h0, PH2 | AB, 0);
    endtask

    initial begin
        reset_n = 0; mem_ready = 0; ir = 16'h0; alu_flags = 4'h0;
        repeat (2) @(posedge clock);
        #1;
        step(0, 0, 4'h0, 18'd0, 0);
        step(1, 0, 4'h0, 18'd0, 0);
        front("add", 16'hC800);
        step(1, 0, 4'h0, PH3 | DRL | FL, 0);
        step(1, 0, 4'h0, PH5 | RFW, 1);
        cur = "load"; ir = 16'h1304;
        step(1, 0, 4'h0, PH1 | RD, 0);
        front("load", 16'h1304);
        step(1, 0, 4'h0, PH3 | DRL, 0);
        step(1, 0, 4'h0, PH4 | RD | SEL, 0);
        step(1, 0, 4'h0, PH4 | RD | SEL, 0);
        step(1, 1, 4'h0, PH4 | RD | SEL, 0);
        step(1, 0, 4'h0, PH5 | RFW | WS, 1);
        front("cmp_z1", 16'hC050);
        step(1, 0, 4'b0010, PH3 | DRL | FL, 1);
        front("be_taken", 16'hB800);
        step(1, 0, 4'h0, PH3 | DRL, 0);
        step(1, 0, 4'h0, PH4 | PCL, 1);
        front("cmp_z0", 16'hC050);
        step(1, 0, 4'b0001, PH3 | DRL | FL, 1);
        front("be_not", 16'hB800);
        step(1, 0, 4'b0010, PH3 | DRL, 0);
        step(1, 1, 4'h0, PH4, 1);
        front("blt", 16'hB900);
        step(1, 0, 4'h0, PH3 | DRL, 0);
        step(1, 0, 4'h0, PH4 | PCL, 1);
        front("bnever", 16'hBC00);
        step(1, 0, 4'h0, PH3 | DRL, 0);
        step(1, 0, 4'h0, PH4, 1);
        front("out", 16'hC0D0);
        step(1, 0, 4'b0010, PH3 | DRL, 0);
        step(1, 0, 4'h0, PH5 | OL, 1);
        front("blt_kept", 16'hB900);
        step(1, 0, 4'h0, PH3 | DRL, 0);
        step(1, 0, 4'h0, PH4 | PCL, 1);
        front("li", 16'h8000);
        step(1, 0, 4'h0, PH3 | DRL, 0);
        step(1, 0, 4'h0, PH5 | RFW, 1);
        front("nop", 16'h8800);
        step(1, 0, 4'h0, PH3 | DRL, 1);
        front("b", 16'hA000);
        step(1, 0, 4'h0, PH3 | DRL, 0);
        step(1, 0, 4'h0, PH4 | PCL, 1);
        front("store_rst", 16'h4000);
        step(1, 0, 4'h0, PH3 | DRL, 0);
        step(1, 0, 4'h0, PH4 | WRN | SEL, 0);
        step(0, 0, 4'h0, PH4 | WRN | SEL, 0);
        step(1, 1, 4'h0, 18'd0, 0);
        front("halt", 16'hC0F0);
        exp_cnt = 16'd1;
        cur = "halted";
        for (int i = 0; i < 20; i++) step(1, 1'($urandom_range(0, 1)), 4'($urandom), HLT, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
